// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame_buffer read-side master:
//   - default bus widths and frame geometry
//   - FSM state encoding used by frame_buffer_reader
//   - helper to size x/y counters (never narrower than one bit)
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_ADDR_WIDTH   = 32;
    localparam int FB_DATA_WIDTH   = 16;
    localparam int FB_H_ACTIVE     = 128;
    localparam int FB_V_ACTIVE     = 80;
    localparam int FB_FRAME_PIXELS = FB_H_ACTIVE * FB_V_ACTIVE;

    // Each buffered beat carries {sof, eol, eof} ahead of the pixel data.
    localparam int FB_FLAG_WIDTH   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fb_state_e;

    // Counter width for a range of n values; a 1-wide range still needs 1 bit.
    function automatic int fb_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_rd_skid_fifo.sv
// ---------------------------------------------------------------------------
// fb_rd_skid_fifo
// Two-entry FIFO that catches read data returning from the frame buffer one
// cycle after each issued address. The head entry drives the output stream
// directly from flops, so it stays stable while the consumer stalls.
// Ports:
//   clk_i, resetn_i   clock, synchronous active-low reset
//   push_i            write push_data_i this cycle
//   push_data_i       {sof, eol, eof, pixel}
//   pop_i             remove the head entry this cycle (only when count_o != 0)
//   head_o            current head entry
//   count_o           occupancy, 0..2
// ---------------------------------------------------------------------------
module fb_rd_skid_fifo #(
    parameter int WIDTH = 19
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [0:1];
    logic [WIDTH-1:0] mem_d [0:1];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q,  count_d;

    // Next-state: pointer/occupancy update for push and pop in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            mem_q[0] <= {WIDTH{1'b0}};
            mem_q[1] <= {WIDTH{1'b0}};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/frame_buffer_reader.sv
// ---------------------------------------------------------------------------
// frame_buffer_reader
// Read-side master for frame_buffer. After start_i it scans one frame in
// raster order from BASE_ADDR upward, absorbs the buffer's 1-cycle read
// latency in a 2-entry skid FIFO, and emits pixels on a valid/ready stream
// tagged with start-of-frame, end-of-line and end-of-frame.
// Ports:
//   clk_i, resetn_i        clock, synchronous active-low reset
//   start_i                begin a frame scan (only honoured when idle)
//   busy_o                 accepted start .. final pixel handshake
//   done_o                 1-cycle pulse after the eof handshake
//   addr_rd_o / data_rd_i  frame_buffer read address / read data (1-cycle)
//   m_valid_o, m_ready_i   output stream handshake
//   m_data_o, m_sof_o, m_eol_o, m_eof_o   output pixel and tags
// ---------------------------------------------------------------------------
module frame_buffer_reader
    import fb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = FB_DATA_WIDTH,
    parameter int                    H_ACTIVE   = FB_H_ACTIVE,
    parameter int                    V_ACTIVE   = FB_V_ACTIVE,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] addr_rd_o,
    input  logic [DATA_WIDTH-1:0] data_rd_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_sof_o,
    output logic                  m_eol_o,
    output logic                  m_eof_o
);

    localparam int XW = fb_cnt_width(H_ACTIVE);
    localparam int YW = fb_cnt_width(V_ACTIVE);
    localparam int BW = DATA_WIDTH + FB_FLAG_WIDTH;

    fb_state_e             state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [XW-1:0]         x_q,      x_d;
    logic [YW-1:0]         y_q,      y_d;
    logic                  infl_q,   infl_d;
    logic [2:0]            iflags_q, iflags_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;

    logic [BW-1:0] head_s;
    logic [1:0]    count_s;
    logic          pop_s;
    logic          eof_pop_s;
    logic          x_last_s;
    logic          y_last_s;
    logic [2:0]    credit_s;
    logic          issue_s;

    assign m_valid_o = (count_s != 2'd0);
    assign pop_s     = m_valid_o & m_ready_i;
    assign eof_pop_s = pop_s & head_s[DATA_WIDTH];
    assign x_last_s  = (x_q == XW'(H_ACTIVE - 1));
    assign y_last_s  = (y_q == YW'(V_ACTIVE - 1));

    // Credits count the entry leaving the FIFO this cycle; without that,
    // steady-state streaming would stall every other cycle.
    assign credit_s = {1'b0, count_s} - {2'b00, pop_s} + {2'b00, infl_q};
    assign issue_s  = (state_q == ST_RUN) && (credit_s < 3'd2);

    // Next-state, scan counters and address generation.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        x_d      = x_q;
        y_d      = y_q;
        iflags_d = iflags_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        infl_d   = issue_s;
        case (state_q)
            ST_IDLE: begin
                addr_d = BASE_ADDR;
                if (start_i) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    x_d     = {XW{1'b0}};
                    y_d     = {YW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s) begin
                    iflags_d = {(x_q == {XW{1'b0}}) && (y_q == {YW{1'b0}}),
                                x_last_s,
                                x_last_s && y_last_s};
                    if (x_last_s && y_last_s) begin
                        // Last pixel issued: address parks on the final word.
                        state_d = ST_DRAIN;
                    end else if (x_last_s) begin
                        addr_d = addr_q + ADDR_WIDTH'(1'b1);
                        x_d    = {XW{1'b0}};
                        y_d    = y_q + YW'(1'b1);
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1'b1);
                        x_d    = x_q + XW'(1'b1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (eof_pop_s) begin
                    state_d = ST_IDLE;
                    addr_d  = BASE_ADDR;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = BASE_ADDR;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and address registers.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= BASE_ADDR;
            x_q      <= {XW{1'b0}};
            y_q      <= {YW{1'b0}};
            infl_q   <= 1'b0;
            iflags_q <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            infl_q   <= infl_d;
            iflags_q <= iflags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Read data arrives the cycle after issue, i.e. while infl_q is set.
    fb_rd_skid_fifo #(
        .WIDTH (BW)
    ) u_skid (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .push_i      (infl_q),
        .push_data_i ({iflags_q, data_rd_i}),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (count_s)
    );

    assign addr_rd_o = addr_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign m_data_o  = head_s[DATA_WIDTH-1:0];
    assign m_sof_o   = head_s[DATA_WIDTH+2];
    assign m_eol_o   = head_s[DATA_WIDTH+1];
    assign m_eof_o   = head_s[DATA_WIDTH];

endmodule

// File: tb/tb_frame_buffer_reader.sv
module tb_frame_buffer_reader;

    localparam int H  = 128;
    localparam int V  = 80;
    localparam int N  = H * V;
    localparam int SH = 4;
    localparam int SV = 2;
    localparam int SN = SH * SV;
    localparam int SBASE = 9216;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        start, ready;
    logic [31:0] addr_rd;
    logic [15:0] data_rd;
    logic        busy, done, m_valid, m_sof, m_eol, m_eof;
    logic [15:0] m_data;

    logic        s_start, s_ready;
    logic [31:0] s_addr;
    logic [15:0] s_data_rd;
    logic        s_busy, s_done, s_valid, s_sof, s_eol, s_eof;
    logic [15:0] s_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem  [0:N-1];
    logic [15:0] smem [0:SN-1];

    frame_buffer_reader u_dut (
        .clk_i(clk), .resetn_i(resetn), .start_i(start), .busy_o(busy), .done_o(done),
        .addr_rd_o(addr_rd), .data_rd_i(data_rd), .m_valid_o(m_valid), .m_ready_i(ready),
        .m_data_o(m_data), .m_sof_o(m_sof), .m_eol_o(m_eol), .m_eof_o(m_eof)
    );

    frame_buffer_reader #(
        .H_ACTIVE(SH), .V_ACTIVE(SV), .BASE_ADDR(32'(SBASE))
    ) u_small (
        .clk_i(clk), .resetn_i(resetn), .start_i(s_start), .busy_o(s_busy), .done_o(s_done),
        .addr_rd_o(s_addr), .data_rd_i(s_data_rd), .m_valid_o(s_valid), .m_ready_i(s_ready),
        .m_data_o(s_data), .m_sof_o(s_sof), .m_eol_o(s_eol), .m_eof_o(s_eof)
    );

    // Frame buffer models: 1-cycle registered read
    always @(posedge clk) begin
        data_rd <= (addr_rd < 32'(N)) ? mem[addr_rd[13:0]] : 16'hDEAD;
        s_data_rd <= (s_addr >= 32'(SBASE) && s_addr < 32'(SBASE + SN)) ?
                     smem[3'(s_addr - 32'(SBASE))] : 16'hBAD0;
    end

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; ready = 1'b0; s_start = 1'b0; s_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || addr_rd !== 32'd0 ||
            m_data !== 16'h0000 || {m_sof, m_eol, m_eof} !== 3'b000)
            begin errors++; $display("FAIL reset: valid=%b busy=%b done=%b addr=%0d data=%h flags=%b required 0/0/0/0/0000/000",
                                     m_valid, busy, done, addr_rd, m_data, {m_sof, m_eol, m_eof}); end
        checks++;
        if (s_addr !== 32'(SBASE) || s_valid !== 1'b0 || s_busy !== 1'b0)
            begin errors++; $display("FAIL reset_small: addr=%0d valid=%b busy=%b required %0d/0/0", s_addr, s_valid, s_busy, SBASE); end
        resetn = 1'b1;
    endtask

    // Runs one frame on the big instance, called right after do_start().
    task automatic scan_frame(input string tag, input bit rnd, input int hold,
                              input int start_pulse_at, input int abort_at);
        int k = 0, n = 0, first_n = -1, eof_n = -1;
        bit stalled = 1'b0;
        logic [15:0] st_data = 16'h0000;
        logic [2:0]  st_flags = 3'b000;
        while (n < 4 * N + 200) begin
            @(negedge clk); n++;
            if (n <= hold) ready = 1'b0;
            else if (rnd) ready = 1'($urandom_range(1, 0));
            else ready = 1'b1;
            start = (n == start_pulse_at);
            if (abort_at >= 0 && k == abort_at) begin
                resetn = 1'b0;
                @(negedge clk); resetn = 1'b1;
                checks++;
                if (m_valid !== 1'b0 || busy !== 1'b0 || addr_rd !== 32'd0 || done !== 1'b0)
                    begin errors++; $display("FAIL %s abort: valid=%b busy=%b addr=%0d done=%b required 0/0/0/0",
                                             tag, m_valid, busy, addr_rd, done); end
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    checks++;
                    if (done !== 1'b0 || m_valid !== 1'b0)
                        begin errors++; $display("FAIL %s post_abort: done=%b valid=%b required 0/0", tag, done, m_valid); end
                end
                return;
            end
            if (eof_n >= 0) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0)
                    begin errors++; $display("FAIL %s done_pulse: done=%b busy=%b valid=%b required 1/0/0", tag, done, busy, m_valid); end
                break;
            end
            checks++;
            if (done !== 1'b0 || busy !== 1'b1)
                begin errors++; $display("FAIL %s in_frame: done=%b busy=%b required 0/1 at cycle %0d", tag, done, busy, n); end
            if (stalled) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== st_data || {m_sof, m_eol, m_eof} !== st_flags)
                    begin errors++; $display("FAIL %s stall_stable: valid=%b data=%h flags=%b required 1/%h/%b",
                                             tag, m_valid, m_data, {m_sof, m_eol, m_eof}, st_data, st_flags); end
            end
            if (m_valid && first_n < 0) begin
                first_n = n;
                checks++;
                if (n != 2) begin errors++; $display("FAIL %s first_valid: cycle %0d required 2", tag, n); end
            end
            if (hold > 0 && n == hold) begin
                checks++;
                if (addr_rd !== 32'd2 || m_valid !== 1'b1 || m_data !== mem[0])
                    begin errors++; $display("FAIL %s hold: addr=%0d valid=%b data=%h required 2/1/%h", tag, addr_rd, m_valid, m_data, mem[0]); end
            end
            if (m_valid && ready) begin
                checks++;
                if (k >= N || m_data !== mem[k] || m_sof !== (k == 0) ||
                    m_eol !== ((k % H) == H - 1) || m_eof !== (k == N - 1))
                    begin errors++; $display("FAIL %s beat %0d: data=%h sof=%b eol=%b eof=%b required %h/%b/%b/%b", tag, k,
                                             m_data, m_sof, m_eol, m_eof, (k < N) ? mem[k] : 16'h0000,
                                             k == 0, (k % H) == H - 1, k == N - 1); end
                if (k == N - 1) eof_n = n;
                k++;
            end
            stalled  = m_valid && !ready;
            st_data  = m_data;
            st_flags = {m_sof, m_eol, m_eof};
        end
        start = 1'b0;
        checks++;
        if (k != N || eof_n < 0)
            begin errors++; $display("FAIL %s beat_count: got %0d required %0d (eof seen=%0d)", tag, k, N, eof_n >= 0); end
        if (!rnd && hold == 0) begin
            checks++;
            if (eof_n + 1 != N + 2)
                begin errors++; $display("FAIL %s frame_cycles: got %0d required %0d", tag, eof_n + 1, N + 2); end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 || addr_rd !== 32'd0)
                begin errors++; $display("FAIL %s idle_after: done=%b valid=%b busy=%b addr=%0d required 0/0/0/0",
                                         tag, done, m_valid, busy, addr_rd); end
        end
    endtask

    task automatic test_full_frame();
        do_start(); scan_frame("full", 1'b0, 0, -1, -1);
    endtask

    task automatic test_back_to_back();
        do_start(); scan_frame("b2b_restart", 1'b0, 0, 3000, -1);
    endtask

    task automatic test_random_backpressure();
        do_start(); scan_frame("rnd_ready", 1'b1, 0, -1, -1);
    endtask

    task automatic test_stall_start();
        do_start(); scan_frame("stall", 1'b0, 10, -1, -1);
    endtask

    task automatic test_midframe_reset();
        do_start(); scan_frame("abort", 1'b0, 0, -1, 500);
        do_start(); scan_frame("after_abort", 1'b0, 0, -1, -1);
    endtask

    task automatic test_small(input bit rnd);
        int k = 0, eof_n = -1, dones = 0;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        for (int n = 1; n < 200; n++) begin
            @(negedge clk);
            s_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            checks++;
            if (s_addr < 32'(SBASE) || s_addr >= 32'(SBASE + SN))
                begin errors++; $display("FAIL small_addr: got %0d required %0d..%0d", s_addr, SBASE, SBASE + SN - 1); end
            if (s_done) begin
                dones++;
                checks++;
                if (eof_n < 0 || n != eof_n + 1)
                    begin errors++; $display("FAIL small_done_timing: cycle %0d required %0d", n, eof_n + 1); end
            end
            if (s_valid && s_ready) begin
                checks++;
                if (k >= SN || s_data !== smem[k[2:0]] || s_sof !== (k == 0) ||
                    s_eol !== ((k % SH) == SH - 1) || s_eof !== (k == SN - 1))
                    begin errors++; $display("FAIL small_beat %0d: data=%h sof=%b eol=%b eof=%b required %h/%b/%b/%b", k,
                                             s_data, s_sof, s_eol, s_eof, smem[k[2:0]], k == 0,
                                             (k % SH) == SH - 1, k == SN - 1); end
                if (k == SN - 1) eof_n = n;
                k++;
            end
            if (eof_n >= 0 && n > eof_n + 4) break;
        end
        checks++;
        if (k != SN || dones != 1 || s_busy !== 1'b0 || s_addr !== 32'(SBASE))
            begin errors++; $display("FAIL small_summary: beats=%0d dones=%0d busy=%b addr=%0d required %0d/1/0/%0d",
                                     k, dones, s_busy, s_addr, SN, SBASE); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 16'(i);
        smem[0] = 16'hFFFF;
        for (int i = 1; i < SN; i++) smem[i] = 16'(i);
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_random_backpressure();
        test_stall_start();
        test_midframe_reset();
        test_small(1'b0);
        test_small(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer_reader.md
Name: frame_buffer_reader

Overview:
- Read-side master for frame_buffer; drives its addr_rd0 port and consumes its Data_out0.
- After a start strobe, scans one full frame in raster order, BASE_ADDR upward, and emits pixels on a valid/ready stream with start-of-frame, end-of-line and end-of-frame flags.
- Absorbs the frame_buffer's fixed 1-cycle read latency under downstream backpressure, with no lost or duplicated pixels.
- Feeds the display/scan-out path.

Parameters:
- ADDR_WIDTH, 32, width of frame_buffer address bus.
- DATA_WIDTH, 16, pixel width.
- H_ACTIVE, 128, pixels per line.
- V_ACTIVE, 80, lines per frame. Default H_ACTIVE*V_ACTIVE = 10240 = 10 BRAMs x 1024.
- BASE_ADDR, 0, address of pixel (0,0).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- resetn_i  in  1  synchronous, active-low reset.
- start_i  in  1  start one frame scan; sampled only in IDLE.
- busy_o  out  1  high from accepted start until the last pixel handshake.
- done_o  out  1  one-cycle pulse, the cycle after the final (eof) handshake.
- addr_rd_o  out  ADDR_WIDTH  to frame_buffer addr_rd0; registered.
- data_rd_i  in  DATA_WIDTH  from frame_buffer Data_out0; holds mem[addr_rd_o of previous cycle].
- m_valid_o  out  1  output pixel valid.
- m_ready_i  in  1  downstream ready.
- m_data_o  out  DATA_WIDTH  pixel.
- m_sof_o  out  1  high on pixel (0,0).
- m_eol_o  out  1  high on last pixel of each line.
- m_eof_o  out  1  high on last pixel of frame.

Behaviour:
- Reset (resetn_i=0 at an edge): state=IDLE; addr_rd_o=BASE_ADDR; busy_o=0; done_o=0; m_valid_o=0; m_data_o=0; all flags 0; x/y counters, in-flight bit and buffer cleared. Reset mid-frame aborts the frame; no done_o.
- FSM states:
  - IDLE: start_i=1 -> RUN; busy_o=1; counters=0; addr_rd_o=BASE_ADDR.
  - RUN: issue reads; after the issue of pixel (H_ACTIVE-1, V_ACTIVE-1) -> DRAIN.
  - DRAIN: no issue; when the eof beat handshakes -> IDLE, busy_o=0, done_o=1 for one cycle.
- start_i in RUN/DRAIN is ignored (no queuing).
- Issue rule: a cycle is an issue cycle iff state=RUN and (buffer occupancy + in-flight) < 2.
  - On issue, addr_rd_o increments at the edge; x wraps at H_ACTIVE-1 and y increments.
  - sof/eol/eof are computed from x,y at issue and pipelined alongside.
  - The in-flight bit is set for the next cycle; that cycle data_rd_i plus flags are written to the buffer.
- addr_rd_o never passes BASE_ADDR+H_ACTIVE*V_ACTIVE-1; it holds that value in DRAIN and returns to BASE_ADDR in IDLE.
- Output buffer: 2-entry FIFO, head drives m_*. m_data_o and flags stay stable while m_valid_o=1 and m_ready_i=0.
- Simultaneous buffer write and read is allowed at any occupancy ≤ 2 (credit rule prevents overflow).
- Latency: start_i high at edge E -> first issue cycle E..E+1 -> m_valid_o=1 after edge E+2.
- Throughput: with m_ready_i held 1, one pixel per cycle, no bubbles. A frame takes H_ACTIVE*V_ACTIVE+2 cycles to done_o.
- Arithmetic: x, y counters are $clog2-sized; address add is unsigned ADDR_WIDTH, no wrap expected.

Decomposition:
- fb_pkg: ADDR_WIDTH/DATA_WIDTH defaults, default H_ACTIVE/V_ACTIVE, FRAME_PIXELS, FSM state encoding (IDLE/RUN/DRAIN).
- Sub-module fb_rd_skid_fifo: 2-entry FIFO of {sof, eol, eof, data}, with push/pop/count.
- Top holds FSM, counters, credit logic.

Test Plan:
- Preload mem[i]=i (i=0..10239) via wr0_i, start, m_ready_i=1 -> 10240 consecutive beats 0x0000..0x27FF. Required flags: sof on beat 0; eol on beats 127, 255, ..., 10239; eof only on beat 10239. First valid 2 edges after start; done_o pulses once, cycle after beat 10239.
- Same preload, m_ready_i pseudo-random (~50%) -> exact sequence 0..0x27FF, no drop/dup; m_data_o constant during every valid&!ready stall.
- Start, m_ready_i=0 for 10 cycles -> addr_rd_o advances at most 2 (BASE+2), m_valid_o=1 holding 0x0000; release -> continuous 0,1,2,... order.
- start_i pulsed again mid-frame -> ignored, single done_o. Start after done_o -> identical second frame.
- resetn_i=0 for one edge at beat ~500 -> next cycle m_valid_o=0, busy_o=0, addr_rd_o=BASE_ADDR, no done_o. New start -> full frame from 0x0000.
- BASE_ADDR=9216, H_ACTIVE=4, V_ACTIVE=2, mem[9216]=0xFFFF, mem[9217..9223]=1..7 -> reads 9216..9223 only; output FFFF,1..7; eol on beats 3, 7; eof on beat 7.
